// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush
// controller (FSM state enum, x0 address, NOP used by stage flush muxes).
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } pipe_state_t;

  localparam int REG_ZERO = 0;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// sat_counter: W-bit up counter, sync active-high Reset, sticks at all-ones.
// Ports: Clk, Reset, inc (count enable), count (current value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: per-stage enables/flushes for load-use, taken branch
// and mul/div start/done. Ports: hazard inputs from ID/EX, mc_done from the
// multi-cycle unit; enables, flushes, sticky mc_timeout and perf counters.
// Perf counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mc_start,
  input  logic                  mc_done,
  output logic                  pc_enable,
  output logic                  ifid_enable,
  output logic                  idex_enable,
  output logic                  exmem_enable,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  mc_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_events
);

  localparam int TW = $clog2(MC_TIMEOUT + 1);

  pipe_state_t   state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          mct_q, mct_d;
  logic          load_use;

  assign load_use = ex_mem_read
    && (ex_rd != REG_ADDR_W'(REG_ZERO))
    && ((id_uses_rs1 && (id_rs1 == ex_rd))
     || (id_uses_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    mct_d        = mct_q;
    pc_enable    = 1'b1;
    ifid_enable  = 1'b1;
    idex_enable  = 1'b1;
    exmem_enable = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    if (Reset) begin
      pc_enable    = 1'b0;
      ifid_enable  = 1'b0;
      idex_enable  = 1'b0;
      exmem_enable = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      state_d      = RUN;
      tcnt_d       = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          // Branch kills the ID instruction, so a
          // coincident load-use stall is moot.
          if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (ex_mc_start) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
            exmem_flush = 1'b1;
            state_d     = MC_WAIT;
            tcnt_d      = '0;
          end else if (load_use) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            state_d = RUN;
          end else if (tcnt_q == TW'(MC_TIMEOUT)) begin
            state_d = RUN;
            mct_d   = 1'b1;
          end else begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_enable = 1'b0;
            exmem_flush = 1'b1;
            tcnt_d      = tcnt_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      mct_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      mct_q   <= mct_d;
    end
  end

  assign mc_timeout = mct_q;

`ifdef PIPE_PERF_CNT_EN
  logic any_flush;
  assign any_flush = ifid_flush | idex_flush | exmem_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (~pc_enable),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (any_flush),
    .count (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed scoreboard bench for pipeline_stall_ctrl.
// Expected controls/counters are queued at drive time, checked mid-cycle.
module tb_pipeline_stall_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pc,ifid,idex,exmem enables, ifid,idex,exmem flushes}
  localparam logic [6:0] C_RST  = 7'b0000_111;
  localparam logic [6:0] C_RUN  = 7'b1111_000;
  localparam logic [6:0] C_LU   = 7'b0011_010;
  localparam logic [6:0] C_BR   = 7'b1111_110;
  localparam logic [6:0] C_FRZ  = 7'b0001_001;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        ex_mem_read, ex_branch_taken;
  logic        ex_mc_start, mc_done;
  logic        pc_enable, ifid_enable;
  logic        idex_enable, exmem_enable;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        mc_timeout;
  logic [31:0] stall_cycles, flush_events;

  pipeline_stall_ctrl #(
    .REG_ADDR_W (5),
    .MC_TIMEOUT (8),
    .CNT_W      (32)
  ) dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_mc_start     (ex_mc_start),
    .mc_done         (mc_done),
    .pc_enable       (pc_enable),
    .ifid_enable     (ifid_enable),
    .idex_enable     (idex_enable),
    .exmem_enable    (exmem_enable),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .mc_timeout      (mc_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [6:0]  ctl;
    logic        chk;
    logic        mct;
    logic [31:0] st;
    logic [31:0] fl;
  } exp_t;

  exp_t q[$];
  int   n_eval = 0;
  int   n_fail = 0;
  logic [31:0] m_st = '0;
  logic [31:0] m_fl = '0;
  logic        m_mct = 1'b0;
  logic        chk_en = 1'b0;

  task automatic idle();
    Reset = 1'b0;
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd3;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    ex_mc_start = 1'b0; mc_done = 1'b0;
  endtask

  task automatic step(input string tag,
                      input logic [6:0] ctl);
    exp_t e, g;
    logic [6:0] obs;
    e.tag = tag;
    e.ctl = ctl;
    e.chk = chk_en;
    e.mct = m_mct;
    e.st  = PERF ? m_st : 32'd0;
    e.fl  = PERF ? m_fl : 32'd0;
    q.push_back(e);
    @(negedge Clk);
    g = q.pop_front();
    obs = {pc_enable, ifid_enable, idex_enable,
           exmem_enable, ifid_flush, idex_flush,
           exmem_flush};
    n_eval++;
    assert (obs === g.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl obs=%b exp=%b",
             g.tag, obs, g.ctl);
    end
    if (g.chk) begin
      n_eval++;
      assert (mc_timeout === g.mct) else begin
        n_fail++;
        $error("FAIL %s mc_timeout obs=%b exp=%b",
               g.tag, mc_timeout, g.mct);
      end
      n_eval++;
      assert (stall_cycles === g.st) else begin
        n_fail++;
        $error("FAIL %s stall_cycles obs=%0d exp=%0d",
               g.tag, stall_cycles, g.st);
      end
      n_eval++;
      assert (flush_events === g.fl) else begin
        n_fail++;
        $error("FAIL %s flush_events obs=%0d exp=%0d",
               g.tag, flush_events, g.fl);
      end
    end
    if (Reset) begin
      m_st = '0; m_fl = '0; m_mct = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (!ctl[6]) m_st = m_st + 1;
      if (|ctl[2:0]) m_fl = m_fl + 1;
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    step("rst0", C_RST);
    step("rst1", C_RST);
    idle();
    step("run0", C_RUN);
    step("run1", C_RUN);

    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    step("lu_rs2", C_LU);
    idle();
    step("lu_after", C_RUN);

    ex_mem_read = 1'b1; ex_rd = 5'd0;
    id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    step("lu_x0", C_RUN);
    ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
    step("lu_nouse", C_RUN);
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step("lu_rs1", C_LU);
    ex_mem_read = 1'b0;
    step("nolu", C_RUN);

    ex_mem_read = 1'b1; id_uses_rs2 = 1'b1;
    ex_branch_taken = 1'b1;
    step("br_lu", C_BR);
    idle();
    step("br_after", C_RUN);

    mc_done = 1'b1;
    step("done_in_run", C_RUN);
    idle();
    ex_mc_start = 1'b1;
    step("mc_start", C_FRZ);
    ex_mc_start = 1'b0;
    ex_branch_taken = 1'b1;
    step("mc_w1", C_FRZ);
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    step("mc_w2", C_FRZ);
    idle();
    step("mc_w3", C_FRZ);
    step("mc_w4", C_FRZ);
    mc_done = 1'b1;
    step("mc_done", C_RUN);
    idle();
    ex_branch_taken = 1'b1;
    step("mc_back_run", C_BR);
    idle();

    ex_mc_start = 1'b1;
    step("to_start", C_FRZ);
    idle();
    for (int i = 0; i < 8; i++)
      step("to_wait", C_FRZ);
    step("to_release", C_RUN);
    m_mct = 1'b1;
    step("to_sticky0", C_RUN);
    mc_done = 1'b1;
    step("to_sticky1", C_RUN);
    idle();
    step("to_sticky2", C_RUN);

    ex_mc_start = 1'b1;
    step("rw_start", C_FRZ);
    idle();
    step("rw_wait", C_FRZ);
    Reset = 1'b1;
    step("rw_reset", C_RST);
    idle();
    step("rw_run0", C_RUN);
    step("rw_run1", C_RUN);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
